sn_reg_bridge: RTL

SN_REG_BRIDGE -- requirements
Module: sn_reg_bridge

---
 rtl/sn_reg_bridge.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sn_reg_bridge.sv
// Byte-stream to register-bus bridge: header/address/data bytes in, prot accesses out, read words back as bytes.
// Optional write acknowledge byte under SN_REG_BRIDGE_WRITE_ACK_EN; tx_ready stalls RSEND/ACK, rx bytes outside IDLE/ADDR/WDATA are dropped.
module sn_reg_bridge #(
  parameter int P_ADDR_BYTES         = 1,
  parameter int P_DATA_BYTES         = 1,
  parameter int P_PROT_WATCHDOG_TIME = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      tx_valid,
  output logic [7:0]                tx_data,
  input  logic                      tx_ready,
  output logic                      prot_enable,
  output logic                      prot_r0w1,
  output logic [8*P_ADDR_BYTES-1:0] prot_addr,
  output logic [8*P_DATA_BYTES-1:0] prot_wdata,
  input  logic [8*P_DATA_BYTES-1:0] prot_rdata,
  input  logic                      prot_ready,
  output logic                      err_timeout,
  output logic                      err_overrun
);

  localparam int AW  = 8 * P_ADDR_BYTES;
  localparam int DW  = 8 * P_DATA_BYTES;
  localparam int WDW = $clog2(P_PROT_WATCHDOG_TIME + 1);

  localparam logic [WDW-1:0] WD_MAX    = WDW'(P_PROT_WATCHDOG_TIME);
  localparam logic [2:0]     ADDR_LAST = 3'(P_ADDR_BYTES - 1);
  localparam logic [2:0]     DATA_LAST = 3'(P_DATA_BYTES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_WACC  = 3'd3;
  localparam logic [2:0] ST_RACC  = 3'd4;
  localparam logic [2:0] ST_RSEND = 3'd5;
`ifdef SN_REG_BRIDGE_WRITE_ACK_EN
  localparam logic [2:0] ST_ACK   = 3'd6;
`endif

  logic [2:0]     state_q, state_d;
  logic           r0w1_q, r0w1_d;
  logic [6:0]     words_q, words_d;
  logic [2:0]     byte_q, byte_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_to_q, err_to_d;
  logic           err_ov_q, err_ov_d;
`ifdef SN_REG_BRIDGE_WRITE_ACK_EN
  logic [7:0]     hdr_q, hdr_d;
`endif

  always_comb begin
    state_d  = state_q;
    r0w1_d   = r0w1_q;
    words_d  = words_q;
    byte_d   = byte_q;
    wd_d     = wd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_to_d = 1'b0;
    err_ov_d = 1'b0;
`ifdef SN_REG_BRIDGE_WRITE_ACK_EN
    hdr_d    = hdr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          r0w1_d  = rx_data[7];
          words_d = rx_data[6:0];
          byte_d  = 3'd0;
          wd_d    = '0;
`ifdef SN_REG_BRIDGE_WRITE_ACK_EN
          hdr_d   = rx_data;
`endif
          state_d = ST_ADDR;
        end
      end
      ST_ADDR, ST_WDATA: begin
        // An arriving byte wins over a watchdog expiry in the same cycle.
        if (rx_valid) begin
          wd_d = '0;
          if (state_q == ST_ADDR) begin
            addr_d = (addr_q << 8) | AW'(rx_data);
            if (byte_q == ADDR_LAST) begin
              byte_d  = 3'd0;
              state_d = r0w1_q ? ST_WDATA : ST_RACC;
            end else begin
              byte_d = byte_q + 3'd1;
            end
          end else begin
            wdata_d = (wdata_q << 8) | DW'(rx_data);
            if (byte_q == DATA_LAST) begin
              byte_d  = 3'd0;
              state_d = ST_WACC;
            end else begin
              byte_d = byte_q + 3'd1;
            end
          end
        end else if (wd_q == WD_MAX) begin
          err_to_d = 1'b1;
          wd_d     = '0;
          byte_d   = 3'd0;
          state_d  = ST_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_WACC: begin
        if (rx_valid) err_ov_d = 1'b1;
        if (prot_ready) begin
          addr_d = addr_q + AW'(1);
          if (words_q == 7'd0) begin
`ifdef SN_REG_BRIDGE_WRITE_ACK_EN
            state_d = ST_ACK;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            words_d = words_q - 7'd1;
            state_d = ST_WDATA;
          end
        end
      end
      ST_RACC: begin
        if (rx_valid) err_ov_d = 1'b1;
        if (prot_ready) begin
          rdata_d = prot_rdata;
          byte_d  = 3'd0;
          state_d = ST_RSEND;
        end
      end
      ST_RSEND: begin
        if (rx_valid) err_ov_d = 1'b1;
        if (tx_ready) begin
          rdata_d = rdata_q << 8;
          if (byte_q == DATA_LAST) begin
            byte_d = 3'd0;
            addr_d = addr_q + AW'(1);
            if (words_q == 7'd0) begin
              state_d = ST_IDLE;
            end else begin
              words_d = words_q - 7'd1;
              state_d = ST_RACC;
            end
          end else begin
            byte_d = byte_q + 3'd1;
          end
        end
      end
`ifdef SN_REG_BRIDGE_WRITE_ACK_EN
      ST_ACK: begin
        if (rx_valid) err_ov_d = 1'b1;
        if (tx_ready) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      r0w1_q   <= 1'b0;
      words_q  <= 7'd0;
      byte_q   <= 3'd0;
      wd_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
`ifdef SN_REG_BRIDGE_WRITE_ACK_EN
      hdr_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      r0w1_q   <= r0w1_d;
      words_q  <= words_d;
      byte_q   <= byte_d;
      wd_q     <= wd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
`ifdef SN_REG_BRIDGE_WRITE_ACK_EN
      hdr_q    <= hdr_d;
`endif
    end
  end

  // Strobes decode straight from state so reset drops them without waiting for a clock.
  always_comb begin
    prot_enable = (state_q == ST_WACC) || (state_q == ST_RACC);
    tx_valid    = (state_q == ST_RSEND);
    tx_data     = 8'h00;
    if (state_q == ST_RSEND) tx_data = rdata_q[DW-1 -: 8];
`ifdef SN_REG_BRIDGE_WRITE_ACK_EN
    if (state_q == ST_ACK) begin
      tx_valid = 1'b1;
      tx_data  = hdr_q;
    end
`endif
  end

  assign prot_r0w1   = r0w1_q;
  assign prot_addr   = addr_q;
  assign prot_wdata  = wdata_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule
